// File: rtl/mem_wait_responder.sv
// Memory-side responder for the multicycle control unit's load/store path.
// Single-word read/write requests complete after LATENCY wait states and are
// acknowledged with a one-cycle Ready pulse. Misaligned requests bypass the RAM
// and respond with AddrErr set. Holds a word-addressed RAM of 2**ADDR_W words.
module mem_wait_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2   // wait states, 0..15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              We,
  input  logic [31:0]       Addr,
  input  logic [DATA_W-1:0] WData,
  output logic [DATA_W-1:0] RData,
  output logic              Ready,
  output logic              Busy,
  output logic              AddrErr
);

  typedef enum logic [1:0] {StIdle, StWait, StErr, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                addr_err_q, addr_err_d;
  logic                we_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                accept;
  logic                access;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  // Upper address bits only alias; they are deliberately not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Addr[31:ADDR_W+2];

  // Next-state logic: accept in IDLE/RESP, count down wait states, then respond.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_err_d = addr_err_q;
    accept     = 1'b0;
    access     = 1'b0;
    case (state_q)
      StIdle, StResp: begin
        if (Req) begin
          accept     = 1'b1;
          addr_err_d = 1'b0;
          if (Addr[1:0] != 2'b00) begin
            state_d = StErr;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY);
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = StResp;
        end
      end
      StErr: begin
        addr_err_d = 1'b1;
        state_d    = StResp;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter, latched request and read-data registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      addr_err_q <= 1'b0;
      rdata_q    <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_err_q <= addr_err_d;
      if (accept) begin
        we_q    <= We;
        idx_q   <= Addr[ADDR_W+1:2];
        wdata_q <= WData;
      end
      if (access && !we_q) begin
        rdata_q <= mem[idx_q];
      end
    end
  end

  // RAM write port; contents survive reset, but a write caught by reset is dropped.
  always_ff @(posedge Clk) begin
    if (!Reset && access && we_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign RData   = rdata_q;
  assign Ready   = (state_q == StResp);
  assign Busy    = (state_q == StWait) || (state_q == StErr);
  assign AddrErr = addr_err_q;

endmodule
